// File: rtl/hwpe_ctrl_context_mgr_if.sv
// Shared types and the peripheral configuration port for hwpe_ctrl_context_mgr.
//   hwpe_ctrl_context_mgr_pkg : register-file request and flag structs.
//     The struct widths are fixed at their largest legal values: src is 16 bits
//     (ID_WIDTH <= 16) and context indices are 2 bits (N_CONTEXT <= 4).
//   hwpe_ctrl_context_mgr_if  : request/grant/response bundle.
//     master : req, add, wen, be, data, id (out); gnt, r_valid, r_id (in)
//     slave  : mirror of master
package hwpe_ctrl_context_mgr_pkg;

  typedef struct packed {
    logic [7:0]  addr;   // {context[1:0], register index[5:0]}
    logic        wren;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [15:0] src;
  } regfile_in_t;

  typedef struct packed {
    logic       is_mandatory;
    logic       is_contexted;
    logic       is_read;
    logic       is_testset;
    logic       is_trigger;
    logic       is_critical;
    logic       full_context;
    logic [1:0] pointer_context;
    logic [1:0] running_context;
    logic       true_done;
  } flags_t;

endpackage

interface hwpe_ctrl_context_mgr_if #(
  parameter int ID_WIDTH = 16
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (output req, add, wen, be, data, id, input gnt, r_valid, r_id);
  modport slave  (input req, add, wen, be, data, id, output gnt, r_valid, r_id);
endinterface

// File: rtl/hwpe_ctrl_context_mgr.sv
// Job-context manager for an HWPE peripheral port: decodes configuration
// requests, arbitrates the programming lock between requesters, counts queued
// job contexts and sequences the engine start/done handshake.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   cfg            : configuration request/grant/response (slave modport)
//   regfile_in_o   : request forwarded to the register file
//   flags_o        : decode flags and context state
//   done_i         : job-complete pulse from the engine
//   start_o        : job start pulse
//   clear_o        : 2-cycle soft-clear pulse
//   evt_o          : completion event, one cycle after an accepted done_i
//   busy_o         : engine running or contexts queued
//
// state          | meaning
// UNLOCKED       | no requester is programming a context
// LOCKED         | owner_q holds the lock and may write contexted registers
// IDLE           | engine stopped, waiting for a queued context
// RUNNING        | engine executing the context at running_context
module hwpe_ctrl_context_mgr
  import hwpe_ctrl_context_mgr_pkg::*;
#(
  parameter int N_CONTEXT = 2,
  parameter int ID_WIDTH  = 16,
  parameter int IO_BASE   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hwpe_ctrl_context_mgr_if.slave cfg,
  output regfile_in_t           regfile_in_o,
  output flags_t                flags_o,
  input  logic                  done_i,
  output logic                  start_o,
  output logic                  clear_o,
  output logic                  evt_o,
  output logic                  busy_o
);

  localparam int CW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  localparam int OW = $clog2(N_CONTEXT) + 1;
  localparam logic [5:0] IO_IDX = 6'(IO_BASE);

  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  typedef enum logic {IDLE, RUNNING}    eng_e;

  lock_e               lock_q, lock_d;
  eng_e                eng_q, eng_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [OW-1:0]       occ_q, occ_d;
  logic [CW-1:0]       ptr_q, ptr_d, rptr_q, rptr_d;
  logic [1:0]          clr_q, clr_d;
  logic                evt_q, evt_d;
  logic                r_valid_q, r_valid_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;

  logic          clearing, gnt, is_owner, full;
  logic [5:0]    idx;
  logic [CW-1:0] ctx_field;
  logic          acquire, trigger_wr, clear_wr;
  logic          is_critical, is_testset, is_trigger, true_done;
  logic          is_mandatory, is_contexted, wren;
  logic [1:0]    ctx_sel;

  assign clearing  = (clr_q != 2'd0);
  assign gnt       = cfg.req & ~clearing;
  assign idx       = cfg.add[7:2];
  assign ctx_field = (N_CONTEXT > 1) ? cfg.add[8 +: CW] : '0;
  assign is_owner  = (lock_q == LOCKED) && (owner_q == cfg.id);
  assign full      = (occ_q == OW'(N_CONTEXT));

  assign acquire    = gnt & cfg.wen  & (idx == 6'd1);
  assign trigger_wr = gnt & ~cfg.wen & (idx == 6'd0);
  assign clear_wr   = gnt & ~cfg.wen & (idx == 6'd5);

  assign true_done   = done_i & (eng_q == RUNNING) & ~clearing & rst_ni;
  assign is_critical = acquire & (lock_q == LOCKED) & ~is_owner;
  // A done in the same cycle frees a slot, so a full queue does not block it.
  assign is_testset  = acquire & ~is_critical & ~(full & ~true_done);
  assign is_trigger  = trigger_wr & is_owner;

  assign is_mandatory = gnt & (idx < 6'd7);
  assign is_contexted = gnt & (idx >= IO_IDX);
  assign wren         = gnt & ~cfg.wen & ~is_mandatory & (~is_contexted | is_owner);

  // Writes target the context being programmed; reads pick the addressed one.
  assign ctx_sel = ~is_contexted ? 2'd0 : (cfg.wen ? 2'(ctx_field) : 2'(ptr_q));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q    <= UNLOCKED;
      owner_q   <= '0;
      eng_q     <= IDLE;
      occ_q     <= '0;
      ptr_q     <= '0;
      rptr_q    <= '0;
      clr_q     <= 2'd0;
      evt_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
    end else begin
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      eng_q     <= eng_d;
      occ_q     <= occ_d;
      ptr_q     <= ptr_d;
      rptr_q    <= rptr_d;
      clr_q     <= clr_d;
      evt_q     <= evt_d;
      r_valid_q <= r_valid_d;
      r_id_q    <= r_id_d;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    owner_d   = owner_q;
    eng_d     = eng_q;
    occ_d     = occ_q;
    ptr_d     = ptr_q;
    rptr_d    = rptr_q;
    clr_d     = clr_q;
    evt_d     = true_done;
    r_valid_d = gnt;
    r_id_d    = gnt ? cfg.id : r_id_q;
    if (clearing) begin
      // State is frozen during the clear window and wiped on its last cycle.
      clr_d = clr_q - 2'd1;
      if (clr_q == 2'd1) begin
        lock_d  = UNLOCKED;
        owner_d = '0;
        eng_d   = IDLE;
        occ_d   = '0;
        ptr_d   = '0;
        rptr_d  = '0;
        r_id_d  = '0;
      end
    end else begin
      if (is_testset && lock_q == UNLOCKED) begin
        lock_d  = LOCKED;
        owner_d = cfg.id;
      end
      if (is_trigger) begin
        lock_d = UNLOCKED;
        ptr_d  = (ptr_q == CW'(N_CONTEXT - 1)) ? '0 : ptr_q + CW'(1);
      end
      occ_d = occ_q + OW'(is_trigger) - OW'(true_done);
      case (eng_q)
        IDLE:    if (occ_q != '0) eng_d = RUNNING;
        RUNNING: if (true_done)   eng_d = IDLE;
        default: eng_d = IDLE;
      endcase
      if (true_done) rptr_d = (rptr_q == CW'(N_CONTEXT - 1)) ? '0 : rptr_q + CW'(1);
      if (clear_wr) clr_d = 2'd2;
    end
  end

  always_comb begin
    cfg.gnt     = gnt;
    cfg.r_valid = r_valid_q;
    cfg.r_id    = r_id_q;

    regfile_in_o.addr  = {ctx_sel, idx};
    regfile_in_o.wren  = wren;
    regfile_in_o.be    = cfg.be;
    regfile_in_o.wdata = cfg.data;
    regfile_in_o.src   = 16'(cfg.id);

    flags_o.is_mandatory    = is_mandatory;
    flags_o.is_contexted    = is_contexted;
    flags_o.is_read         = gnt & cfg.wen;
    flags_o.is_testset      = is_testset;
    flags_o.is_trigger      = is_trigger;
    flags_o.is_critical     = is_critical;
    flags_o.full_context    = full;
    flags_o.pointer_context = 2'(ptr_q);
    flags_o.running_context = 2'(rptr_q);
    flags_o.true_done       = true_done;

    start_o = (eng_q == IDLE) & (occ_q != '0) & ~clearing;
    clear_o = clearing;
    evt_o   = evt_q;
    busy_o  = (eng_q == RUNNING) | (occ_q != '0);
  end

endmodule
